regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between NREQ writeback requesters (e.g. EXU result, LSU load data, CSR read data).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Holds a per-register busy scoreboard so decode can stall on RAW hazards against in-flight producers.
- Sits between the execution units and the register file; drives the register file's wen/waddr/wdata from a registered output stage.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- ADDR_WIDTH, 5, register address width; NREG = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a writeback pending.
- req_waddr  in  NREQ*ADDR_WIDTH  destination of requester i, slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NREQ*DATA_WIDTH  data of requester i, slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] && req_ready[i].
- issue_valid  in  1  decode issues an instruction that will write issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register being reserved.
- chk_addr  in  ADDR_WIDTH  register queried by decode.
- chk_busy  out  1  chk_addr has an outstanding producer.
- rf_wen  out  1  to register file wen.
- rf_waddr  out  ADDR_WIDTH  to register file waddr.
- rf_wdata  out  DATA_WIDTH  to register file wdata.

Behaviour:
- Reset (async, rst_n low):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - RR pointer=0, so requester 0 has highest priority.
  - busy bitmap all 0.
  - req_ready is combinational; it evaluates to 0 while rst_n is low.
- Arbitration (combinational, every cycle):
  - Search starts at the pointer and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - No valid requester gives req_ready=0.
  - The register file always accepts, so one grant is issued per cycle and there is no backpressure from the output stage.
  - A requester must hold valid, addr and data stable until its handshake. req_ready may depend on req_valid.
- Pointer update: on a handshake by requester g, pointer <= (g+1) mod NREQ. With no handshake the pointer holds.
- Output stage, 1-cycle latency:
  - A handshake at edge N gives rf_wen=1 with the registered addr/data during cycle N+1. The register file writes at edge N+1.
  - With no handshake, rf_wen=0 on the next cycle and rf_waddr/rf_wdata hold their last values.
- x0 writes: a request with waddr=0 is granted and consumed normally, but rf_wen stays 0 for that slot.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: rf_wen && rf_waddr!=0 clears busy[rf_waddr] at the same edge the register file commits. busy falling therefore means the data is readable from the RF.
  - Set and clear of the same address in one cycle: set wins, because a new producer is in flight.
  - Set and clear of different addresses in one cycle: both apply.
  - busy[0] is constant 0.
  - chk_busy = busy[chk_addr], combinational. It does not forward the in-flight output stage, so it stays 1 through the commit cycle.
- Reset mid-operation: a pending output-stage write is discarded (rf_wen drops immediately), the scoreboard clears, and requesters must re-present their requests.
- Duplicate reservation of an already-busy register is legal; it is cleared by the first commit to that address. Decode is responsible for stalling on chk_busy before issuing.

Decomposition:
- Package regfile_pkg: ADDR_WIDTH/DATA_WIDTH defaults, NREG, and the constant REG_ZERO = 0.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], pointer.
  - Outputs: one-hot gnt[N] and encoded gnt_idx.
  - Purely combinational; reused later for the memory-port arbiter.
- The top module holds the pointer, output register and busy bitmap.

Test Plan:
- Single requester: req0 valid, waddr=5, wdata=0xDEADBEEF at edge N -> req_ready=01; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; rf_wen=0 in N+2.
- Contention fairness: req0 and req1 both held valid for 4 cycles from reset -> grants 0,1,0,1; rf_waddr follows the corresponding addresses in order.
- x0 drop: req1 valid with waddr=0, wdata=0x1234 -> req_ready[1]=1 for one cycle; rf_wen stays 0.
- Scoreboard lifecycle:
  - issue_rd=7 at edge N -> chk_addr=7 reads chk_busy=1 from cycle N+1.
  - Writeback to 7 handshaked at edge M -> chk_busy=1 during cycle M+1, 0 from cycle M+2.
- Set-wins collision: busy[3]=1, commit to 3 (rf_wen=1, rf_waddr=3) in the same cycle as issue_rd=3 -> chk_busy stays 1 for chk_addr=3.
- Async reset: assert rst_n=0 mid-cycle while rf_wen=1 -> rf_wen=0 immediately, all chk_busy=0, and the grant after release goes to req0 when both requesters are valid.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NREG       = 2 ** ADDR_WIDTH;

  // Architectural zero register: writes to it are dropped, it is never busy.
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = '0;

  // Register count for a given address width (used for the busy bitmap size).
  function automatic int num_regs(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at 'pointer' and wraps
// modulo N; the first asserted request wins. Shared with the memory-port arbiter.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   idx;
  logic found;

  // Scan N positions starting at the pointer and grant the first requester.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(pointer) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register-file write port: round-robin grants
// among NREQ requesters, a one-cycle registered output stage driving the RF,
// and a per-register busy scoreboard that decode uses to stall on RAW hazards.
module regfile_wb_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  input  logic [ADDR_WIDTH-1:0]      chk_addr,
  output logic                       chk_busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
);

  import regfile_pkg::*;

  localparam int IW   = $clog2(NREQ);
  localparam int REGS = num_regs(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_ZERO);

  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_data;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [REGS-1:0]       busy_q, busy_d;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are suppressed while reset is held so nothing is consumed then.
  assign req_ready = rst_n ? gnt : '0;
  assign hs        = |req_ready;
  assign gnt_addr  = req_waddr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign gnt_data  = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];

  // Next pointer and output-stage contents; x0 writes are consumed but muted.
  always_comb begin
    ptr_d      = ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (hs) begin
      ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      rf_wen_d   = (gnt_addr != X0);
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
  end

  // Scoreboard update: clear on commit first, then set, so a same-address
  // reservation in the commit cycle wins (a newer producer is in flight).
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q && rf_waddr_q != X0) busy_d[rf_waddr_q] = 1'b0;
    if (issue_valid && issue_rd != X0) busy_d[issue_rd]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers: pointer, output stage and busy bitmap.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the busy bitmap is plain flops rather than a RAM, and it must be
    // reset because a stale busy bit after reset would stall decode forever.
    if (!rst_n) begin
      ptr_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational blocks above.
      ptr_q      <= ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  // The scoreboard lookup does not forward the output stage: a register stays
  // busy through its commit cycle and reads free once the RF holds the data.
  assign chk_busy = busy_q[chk_addr];
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run, all compared against a behavioural model of the rules.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_waddr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [AW-1:0]        chk_addr;
  logic                 chk_busy;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [DW-1:0]        rf_wdata;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state.
  int            m_ptr;
  bit [NREG-1:0] m_busy;
  bit            m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            last_g;

  regfile_wb_arbiter #(
    .NREQ       (NREQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_addr    (chk_addr),
    .chk_busy    (chk_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_busy = '0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    last_g = -1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_waddr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    req_waddr   = '0;
    req_wdata   = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    chk_addr    = '0;
  endtask

  // Advance one rising edge and apply the spec rules to the model; returns
  // 1 ns after the edge so registered outputs can be compared.
  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (m_wen && m_addr != 0) m_busy[m_addr] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (g >= 0) begin
      m_addr = req_waddr[g*AW +: AW];
      m_data = req_wdata[g*DW +: DW];
      m_wen  = (m_addr != 0);
      m_ptr  = (g + 1) % NREQ;
    end else begin
      m_wen = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  // Entered at a falling edge; pulses reset and returns at a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    req_valid = '1;
    model_reset();
    #2;
    vectors++;
    if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wen=%b addr=%0d data=%h, expected 0/0/0",
               rf_wen, rf_waddr, rf_wdata);
    end
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    for (int a = 0; a < NREG; a += 9) begin
      chk_addr = AW'(a);
      #1;
      vectors++;
      if (chk_busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy[%0d]: got %b expected 0", a, chk_busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    tick();
    vectors++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write: got wen=%b addr=%0d data=%h, expected 1/5/deadbeef",
               rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    set_req(0, 1'b0, 5'd5, 32'hDEADBEEF);
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL single_idle_ready: got %b expected 00", req_ready);
    end
    tick();
    vectors++;
    if (rf_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wen_drop: got %b expected 0", rf_wen);
    end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_rdy;
    logic [AW-1:0]   exp_addr;
    do_reset();
    set_req(0, 1'b1, 5'd10, 32'hA000_0000);
    set_req(1, 1'b1, 5'd11, 32'hB000_0000);
    for (int k = 0; k < 4; k++) begin
      exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 5'd10 : 5'd11;
      #1;
      vectors++;
      if (req_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL fair_ready[%0d]: got %b expected %b", k, req_ready, exp_rdy);
      end
      tick();
      vectors++;
      if (rf_wen !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== m_data) begin
        miscompares++;
        $display("FAIL fair_write[%0d]: got wen=%b addr=%0d data=%h, expected 1/%0d/%h",
                 k, rf_wen, rf_waddr, rf_wdata, exp_addr, m_data);
      end
      @(negedge clk);
      // The granted requester presents a fresh payload to the same register.
      req_wdata[last_g*DW +: DW] = req_wdata[last_g*DW +: DW] + 32'd1;
    end
    clear_inputs();
  endtask

  task automatic test_x0();
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL x0_ready: got %b expected 10", req_ready);
    end
    tick();
    vectors++;
    if (rf_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_wen: got %b expected 0", rf_wen);
    end
    @(negedge clk);
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_consumed: got %b expected 00", req_ready);
    end
    tick();
    @(negedge clk);
  endtask

  task automatic test_scoreboard();
    chk_addr    = 5'd7;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    vectors++;
    if (chk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_before_issue: got %b expected 0", chk_busy);
    end
    tick();
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    vectors++;
    if (chk_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_after_issue: got %b expected 1", chk_busy);
    end
    set_req(0, 1'b1, 5'd7, 32'h7777_0007);
    tick();
    @(negedge clk);
    set_req(0, 1'b0, 5'd7, 32'h7777_0007);
    #1;
    vectors++;
    if (chk_busy !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin
      miscompares++;
      $display("FAIL sb_commit_cycle: got busy=%b wen=%b addr=%0d, expected 1/1/7",
               chk_busy, rf_wen, rf_waddr);
    end
    tick();
    @(negedge clk);
    #1;
    vectors++;
    if (chk_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_after_commit: got %b expected 0", chk_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_set_wins();
    chk_addr    = 5'd3;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    tick();
    @(negedge clk);
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd3, 32'hC0FFEE00);
    tick();
    @(negedge clk);
    set_req(0, 1'b0, 5'd3, 32'hC0FFEE00);
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    #1;
    vectors++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || chk_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL setwin_setup: got wen=%b addr=%0d busy=%b, expected 1/3/1",
               rf_wen, rf_waddr, chk_busy);
    end
    tick();
    @(negedge clk);
    issue_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (chk_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL setwin_busy[%0d]: got %b expected 1", k, chk_busy);
      end
      tick();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom));
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = AW'($urandom_range(0, 7));
      chk_addr    = AW'($urandom_range(0, 7));
      #1;
      vectors++;
      if (req_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready());
      end
      vectors++;
      if (chk_busy !== m_busy[chk_addr]) begin
        miscompares++;
        $display("FAIL rand_busy[%0d] addr %0d: got %b expected %b",
                 cyc, chk_addr, chk_busy, m_busy[chk_addr]);
      end
      tick();
      vectors++;
      if (rf_wen !== m_wen || (m_wen && (rf_waddr !== m_addr || rf_wdata !== m_data))) begin
        miscompares++;
        $display("FAIL rand_write[%0d]: got wen=%b addr=%0d data=%h, expected %b/%0d/%h",
                 cyc, rf_wen, rf_waddr, rf_wdata, m_wen, m_addr, m_data);
      end
      @(negedge clk);
      if (last_g >= 0) req_valid[last_g] = 1'b0;
    end
    clear_inputs();
    for (int a = 0; a < NREG; a++) begin
      chk_addr = AW'(a);
      #1;
      vectors++;
      if (chk_busy !== m_busy[a]) begin
        miscompares++;
        $display("FAIL sweep_busy[%0d]: got %b expected %b", a, chk_busy, m_busy[a]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    chk_addr    = 5'd12;
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    tick();
    @(negedge clk);
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd12, 32'h1200_0012);
    tick();
    vectors++;
    if (rf_wen !== 1'b1 || chk_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_setup: got wen=%b busy=%b, expected 1/1", rf_wen, chk_busy);
    end
    #1 rst_n = 1'b0;
    model_reset();
    set_req(1, 1'b1, 5'd13, 32'h1300_0013);
    #1;
    vectors++;
    if (rf_wen !== 1'b0 || chk_busy !== 1'b0 || req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL arst_immediate: got wen=%b busy=%b ready=%b, expected 0/0/00",
               rf_wen, chk_busy, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL arst_first_grant: got %b expected 01", req_ready);
    end
    tick();
    vectors++;
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h1200_0012) begin
      miscompares++;
      $display("FAIL arst_replay: got wen=%b addr=%0d data=%h, expected 1/12/12000012",
               rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_scoreboard();
    test_set_wins();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
